// File: rtl/trng_com_rx.sv
// Purpose : 8N1 serial receiver feeding a 2-entry show-ahead byte queue, with RTS flow control to the host.
// Latency : 2-cycle input synchroniser; a byte appears on o_dat/o_valid one cycle after its stop-bit sample.
// Backpressure: RTS holds the host once the queue has one entry; a good frame arriving at a full queue is dropped with o_overrun.
module trng_com_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_serial_data,
    input  logic       i_read,
    output logic [7:0] o_dat,
    output logic       o_valid,
    output logic       o_serial_rts_n,
    output logic       o_new_frame,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // Synchroniser; both stages idle high so reset never looks like a start edge.
    logic sync1;
    logic rx;

    // Receiver state.
    state_t        state;
    logic [CW-1:0] bcnt;
    logic [2:0]    bidx;
    logic [7:0]    sr;

    // Queue: q0 is the head, q1 the second entry.
    logic [7:0] q0;
    logic [7:0] q1;
    logic [1:0] count;

    logic bit_end;
    logic push_vld;
    logic stop_bad;
    logic pop;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= i_serial_data;
            rx    <= sync1;
        end
    end

    assign bit_end  = (bcnt == CNT_LAST);
    // A good stop bit pushes the assembled byte on the same edge it is sampled.
    assign push_vld = (state == S_STOP) && bit_end && rx;
    assign stop_bad = (state == S_STOP) && bit_end && !rx;
    // Reads against an empty queue are ignored.
    assign pop      = i_read && (count != 2'd0);

    // Frame FSM: finds the start edge, samples each bit at its centre, checks the stop bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
            bcnt  <= '0;
            bidx  <= '0;
            sr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx) begin
                        state <= S_START;
                        bcnt  <= '0;
                    end
                end
                S_START: begin
                    // Re-check at mid start bit so a short glitch is rejected.
                    if (bcnt == CNT_HALF) begin
                        if (rx) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                            bcnt  <= '0;
                            bidx  <= '0;
                        end
                    end else begin
                        bcnt <= bcnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        sr   <= {rx, sr[7:1]};
                        bcnt <= '0;
                        if (bidx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bidx <= bidx + 3'd1;
                        end
                    end else begin
                        bcnt <= bcnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                    if (bit_end) begin
                        bcnt  <= '0;
                        state <= rx ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        bcnt <= bcnt + CNT_ONE;
                    end
                end
                S_WAIT_IDLE: begin
                    // A held-low line (break) is waited out instead of re-framed.
                    if (rx) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Show-ahead queue, RTS and the single-cycle status pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            q0             <= '0;
            q1             <= '0;
            count          <= '0;
            o_serial_rts_n <= 1'b0;
            o_new_frame    <= 1'b0;
            o_frame_err    <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            o_new_frame    <= 1'b0;
            o_overrun      <= 1'b0;
            o_frame_err    <= stop_bad;
            // Hold the host as soon as one entry is used; the second slot absorbs a frame already in flight.
            o_serial_rts_n <= (count != 2'd0);
            case ({push_vld, pop})
                2'b10: begin
                    if (count == 2'd2) begin
                        o_overrun <= 1'b1;
                    end else begin
                        o_new_frame <= 1'b1;
                        count       <= count + 2'd1;
                        if (count == 2'd0) begin
                            q0 <= sr;
                        end else begin
                            q1 <= sr;
                        end
                    end
                end
                2'b01: begin
                    q0    <= q1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Pop is applied first, so the push always finds room and count is unchanged.
                    o_new_frame <= 1'b1;
                    if (count == 2'd1) begin
                        q0 <= sr;
                    end else begin
                        q0 <= q1;
                        q1 <= sr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_dat   = q0;
    assign o_valid = (count != 2'd0);

endmodule

// File: tb/tb_trng_com_rx.sv
module tb_trng_com_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       i_reset;
    logic       i_serial_data;
    logic       i_read;
    logic [7:0] o_dat;
    logic       o_valid;
    logic       o_serial_rts_n;
    logic       o_new_frame;
    logic       o_frame_err;
    logic       o_overrun;

    int checks   = 0;
    int failures = 0;

    // Pulse counters maintained by the monitor.
    int n_new   = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int n_multi = 0;

    // Scoreboard of bytes expected to come out of the queue, oldest first.
    logic [7:0] sb[$];

    trng_com_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_serial_data  (i_serial_data),
        .i_read         (i_read),
        .o_dat          (o_dat),
        .o_valid        (o_valid),
        .o_serial_rts_n (o_serial_rts_n),
        .o_new_frame    (o_new_frame),
        .o_frame_err    (o_frame_err),
        .o_overrun      (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_new_frame) n_new++;
            if (o_frame_err) n_ferr++;
            if (o_overrun)   n_ovr++;
            if ((int'(o_new_frame) + int'(o_frame_err) + int'(o_overrun)) > 1) n_multi++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pops one byte: the head must match the oldest scoreboard entry.
    task automatic do_read(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        e = sb.pop_front();
        check(tag, 32'(o_dat), 32'(e));
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
    endtask

    // Drives one 8N1 frame. rd_tick >= 0 pops (and checks the head) during that bit-time tick;
    // rst_tick >= 0 pulses reset at that tick and abandons the frame with the line idle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_tick, input int rst_tick);
        logic [7:0] e;
        for (int t = 0; t < 10 * CPB; t++) begin
            int b;
            b = t / CPB;
            if (b == 0)      i_serial_data = 1'b0;
            else if (b == 9) i_serial_data = stop;
            else             i_serial_data = d[b-1];
            if (t == rd_tick) begin
                check("coll_valid", 32'(o_valid), 32'd1);
                e = sb.pop_front();
                check("coll_head", 32'(o_dat), 32'(e));
                i_read = 1'b1;
            end else begin
                i_read = 1'b0;
            end
            if (t == rst_tick) begin
                i_reset = 1'b1;
                tick();
                i_reset = 1'b0;
                i_serial_data = 1'b1;
                return;
            end
            tick();
        end
        i_read = 1'b0;
    endtask

    task automatic idle(input int n);
        i_serial_data = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int base_new;
        int base_ovr;
        int base_ferr;

        i_reset       = 1'b1;
        i_serial_data = 1'b1;
        i_read        = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();

        // Reset state.
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_dat",   32'(o_dat), 32'h00);
        check("rst_rts",   32'(o_serial_rts_n), 32'd0);
        check("rst_new",   32'(o_new_frame), 32'd0);
        check("rst_ferr",  32'(o_frame_err), 32'd0);
        check("rst_ovr",   32'(o_overrun), 32'd0);
        idle(20);

        // Single byte.
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1);
        idle(4);
        check("single_new", 32'(n_new), 32'd1);
        check("single_rts", 32'(o_serial_rts_n), 32'd1);
        do_read("single_dat");
        check("single_valid_after", 32'(o_valid), 32'd0);
        tick();
        check("single_rts_after", 32'(o_serial_rts_n), 32'd0);
        idle(8);

        // Back-to-back frames, third one overruns.
        base_new = n_new;
        base_ovr = n_ovr;
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(4);
        check("b2b_new", 32'(n_new - base_new), 32'd2);
        check("b2b_ovr", 32'(n_ovr - base_ovr), 32'd1);
        do_read("b2b_first");
        do_read("b2b_second");
        check("b2b_empty", 32'(o_valid), 32'd0);
        idle(8);

        // Glitch on the idle line.
        base_new  = n_new;
        base_ferr = n_ferr;
        i_serial_data = 1'b0;
        repeat (5) tick();
        idle(3 * CPB);
        check("glitch_new",   32'(n_new - base_new), 32'd0);
        check("glitch_ferr",  32'(n_ferr - base_ferr), 32'd0);
        check("glitch_valid", 32'(o_valid), 32'd0);
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, -1, -1);
        idle(4);
        do_read("glitch_next");

        // Framing error followed by a held-low line.
        base_new  = n_new;
        base_ferr = n_ferr;
        send_frame(8'h81, 1'b0, -1, -1);
        i_serial_data = 1'b0;
        repeat (40) tick();
        idle(2 * CPB);
        check("ferr_count", 32'(n_ferr - base_ferr), 32'd1);
        check("ferr_nopush", 32'(n_new - base_new), 32'd0);
        check("ferr_valid", 32'(o_valid), 32'd0);
        sb.push_back(8'h42);
        send_frame(8'h42, 1'b1, -1, -1);
        idle(4);
        do_read("ferr_next");

        // Push/pop collision with a full queue.
        base_new = n_new;
        base_ovr = n_ovr;
        sb.push_back(8'h12);
        sb.push_back(8'h34);
        sb.push_back(8'h99);
        send_frame(8'h12, 1'b1, -1, -1);
        send_frame(8'h34, 1'b1, -1, -1);
        send_frame(8'h99, 1'b1, CPB / 2 + 9 * CPB + 2, -1);
        idle(4);
        check("coll_ovr", 32'(n_ovr - base_ovr), 32'd0);
        check("coll_new", 32'(n_new - base_new), 32'd3);
        do_read("coll_first");
        do_read("coll_second");
        idle(8);

        // Reset in the middle of a frame with a byte already queued.
        send_frame(8'h77, 1'b1, -1, -1);
        idle(4);
        base_new = n_new;
        send_frame(8'hC3, 1'b1, -1, 5 * CPB + 10);
        check("mrst_valid", 32'(o_valid), 32'd0);
        check("mrst_dat",   32'(o_dat), 32'h00);
        check("mrst_rts",   32'(o_serial_rts_n), 32'd0);
        check("mrst_pulses", 32'(int'(o_new_frame) + int'(o_frame_err) + int'(o_overrun)), 32'd0);
        idle(11 * CPB);
        check("mrst_nobyte", 32'(n_new - base_new), 32'd0);
        check("mrst_valid_idle", 32'(o_valid), 32'd0);
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1);
        idle(4);
        do_read("mrst_next");
        idle(4);

        check("pulse_overlap", 32'(n_multi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trng_com_rx.md
# trng_com_rx

Serial receiver that mirrors `trng_com` in the opposite direction. It deserialises 8N1 frames arriving on the host serial line into bytes and buffers them in a 2-entry show-ahead queue. It signals flow control back to the host on an RTS line. It sits beside `trng_com` in `trng_top` and lets the host send command bytes (reset, read-length, mode) to the TRNG.

## Interface
Parameters:
- CLKS_PER_BIT, 868, i_clk cycles per serial bit (100 MHz / 115200). Legal range is ≥ 4; counter width is $clog2(CLKS_PER_BIT).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_serial_data  in  1  asynchronous serial line; idle high; LSB first; 1 start, 8 data, 1 stop bit
- i_read  in  1  consumer pops the head byte when i_read & o_valid
- o_dat  out  8  head byte of the queue; valid only while o_valid is high
- o_valid  out  1  queue not empty
- o_serial_rts_n  out  1  flow control to host; 0 = host may send; 1 = hold
- o_new_frame  out  1  1-cycle pulse for each frame accepted into the queue
- o_frame_err  out  1  1-cycle pulse when a stop bit samples 0
- o_overrun  out  1  1-cycle pulse when a good frame is dropped because the queue is full

## Operation
- **Synchroniser:** i_serial_data passes through 2 flops, both reset to 1. All logic uses the synchronised value `rx`.
- **State machine:** IDLE, START, DATA, STOP, WAIT_IDLE. One bit counter `bcnt` counts 0..CLKS_PER_BIT-1. One bit index `bidx` counts 0..7.
- **IDLE:** when rx==0, go to START and clear bcnt.
- **START:** when bcnt==CLKS_PER_BIT/2-1 (mid start bit), sample rx.
  - rx==1: false start (glitch); return to IDLE with no output.
  - rx==0: clear bcnt and bidx, go to DATA.
- **DATA:** when bcnt==CLKS_PER_BIT-1, sample rx into the shift register as {rx, sr[7:1]} and clear bcnt.
  - After bidx==7 is sampled, go to STOP; otherwise increment bidx.
- **STOP:** when bcnt==CLKS_PER_BIT-1, sample rx.
  - rx==1: push sr and go to IDLE. Returning at mid stop bit lets a back-to-back start edge be caught.
  - rx==0: pulse o_frame_err, discard sr, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until rx==1, then go to IDLE. A break condition therefore never produces repeated frames.
- **Queue:** 2 entries, show-ahead.
  - o_dat is the oldest entry.
  - A push when count==2 and no pop in the same cycle drops the byte and pulses o_overrun; o_new_frame is not pulsed.
  - A push and pop in the same cycle at count==2: the pop is applied first and the push is accepted; count stays 2 and there is no overrun.
  - A push and pop in the same cycle at count==1: count stays 1, and o_dat becomes the pushed byte.
  - i_read while o_valid==0 is ignored.
- **o_new_frame:** pulses for every accepted push.
- **Flow control:** o_serial_rts_n is registered and equals (count ≥ 1). One buffered slot remains for the frame already in flight when RTS deasserts.
- **Reset:** i_reset at any point, including mid-frame, returns the FSM to IDLE and clears bcnt, bidx, sr and the queue. A partial frame is lost. Any later data bits are treated as start edges; the false-start check and WAIT_IDLE path resynchronise the receiver.

## Timing
- **Reset values:** o_valid=0, o_dat=8'h00, o_serial_rts_n=0, o_new_frame=0, o_frame_err=0, o_overrun=0; synchroniser flops =1; state=IDLE.
- **Input latency:** 2 cycles from the pin to rx.
- **Sample points:** let t0 be the first cycle IDLE sees rx==0.
  - Start bit is sampled at t0+CLKS_PER_BIT/2.
  - Data bit k is sampled at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
  - Stop bit is sampled at t0+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- **Push timing:** the push occurs on the stop-sample edge. o_valid, o_new_frame and o_dat update on the following cycle. o_serial_rts_n rises 1 cycle after o_valid.
- **Pop timing:** a pop updates o_dat/o_valid on the next edge; there is no read latency.
- **Pulse outputs:** exactly 1 cycle wide. They are never asserted together for the same frame.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- **Single byte:** send 0xA5 framed with a good stop bit, i_read low -> one o_new_frame pulse; o_valid=1; o_dat=8'hA5; o_serial_rts_n=1. Assert i_read for 1 cycle -> o_valid=0 and o_serial_rts_n=0 one cycle later.
- **Back-to-back, then overrun:** send 0x00, 0xFF, 0x3C with no idle gap and no reads -> queue holds 0x00 then 0xFF; o_overrun pulses once at the 0x3C stop sample. Two pops return 0x00 then 0xFF.
- **Glitch:** drive a 5-cycle low pulse on the idle line -> no pulses; o_valid stays 0; FSM back in IDLE. A following frame 0x5A is received correctly.
- **Framing error:** send 0x81 with stop bit 0 and hold the line low for 40 cycles -> exactly one o_frame_err pulse and no push. The next valid frame 0x42 is received.
- **Push/pop collision:** with 2 entries queued, assert i_read on the push cycle of a third frame 0x99 -> no o_overrun; queue contents become {second byte, 0x99}.
- **Reset mid-frame:** assert i_reset for 1 cycle after data bit 3 of 0xC3 -> all outputs return to reset values and no byte appears. A frame 0x11 sent after the line has idled ≥ 10 bit times is received correctly.
